// File: rtl/shared_net_arbiter.sv
// ============================================================================
// Module   : shared_net_arbiter
// Purpose  : Round-robin owner selection for one shared WIDTH-bit net, with
//            registered data drive, idle pull pattern and turnaround bubble.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shared_net_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 8,
    parameter int IDLE_VAL = 1,
    parameter int MAX_HOLD = 16,
    parameter int INVERT   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*WIDTH-1:0]      data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic [WIDTH-1:0]              net_out,
    output logic                          net_valid,
    output logic                          timeout_pulse
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [WIDTH-1:0]   IDLE_PAT  = (IDLE_VAL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [CW-1:0]      HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [OW-1:0]      PTR_INIT  = OW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_TURN = 2'd2
    } state_t;

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [CW-1:0]   hold_cnt;

    logic [OW-1:0]   sel;
    logic            sel_valid;
    logic [WIDTH-1:0] owner_data;
    logic [WIDTH-1:0] beat;
    logic            req_own;
    logic            last_own;
    logic            hold_expired;

    // Rotating search: walk from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                sel       = OW'((int'(ptr) + k) % NUM_REQ);
                sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        owner_data   = data[int'(owner)*WIDTH +: WIDTH];
        beat         = (INVERT != 0) ? ~owner_data : owner_data;
        req_own      = req[owner];
        last_own     = last[owner];
        hold_expired = (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            grant         <= '0;
            owner         <= '0;
            net_out       <= IDLE_PAT;
            net_valid     <= 1'b0;
            timeout_pulse <= 1'b0;
            ptr           <= PTR_INIT;
            hold_cnt      <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    net_out   <= IDLE_PAT;
                    net_valid <= 1'b0;
                    if (sel_valid) begin
                        grant    <= ONE_HOT0 << sel;
                        owner    <= sel;
                        hold_cnt <= '0;
                        state    <= S_OWN;
                    end
                end
                S_OWN: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (!req_own) begin
                        // Owner vanished without a final beat: drive idle immediately.
                        net_out   <= IDLE_PAT;
                        net_valid <= 1'b0;
                        grant     <= '0;
                        ptr       <= owner;
                        state     <= S_TURN;
                    end else begin
                        net_out   <= beat;
                        net_valid <= 1'b1;
                        if (last_own || hold_expired) begin
                            grant <= '0;
                            ptr   <= owner;
                            state <= S_TURN;
                        end
                        if (!last_own && hold_expired) begin
                            timeout_pulse <= 1'b1;
                        end
                    end
                end
                S_TURN: begin
                    net_out   <= IDLE_PAT;
                    net_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    grant     <= '0;
                    net_out   <= IDLE_PAT;
                    net_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shared_net_arbiter.sv
// ============================================================================
// Module   : tb_shared_net_arbiter
// Purpose  : Directed + random stimulus on three parameter variants, checked
//            cycle by cycle against a transaction-level ownership model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shared_net_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int MH  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*W-1:0]  data;

    logic [N-1:0] g0, g1, g2;
    logic [1:0]   o0, o1, o2;
    logic [W-1:0] n0, n1, n2;
    logic         v0, v1, v2;
    logic         t0, t1, t2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Plain drive, pull1 idle
    shared_net_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDLE_VAL(1), .MAX_HOLD(MH), .INVERT(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .last(last), .data(data),
        .grant(g0), .owner(o0), .net_out(n0), .net_valid(v0), .timeout_pulse(t0));
    // Inverted drive, pull1 idle
    shared_net_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDLE_VAL(1), .MAX_HOLD(MH), .INVERT(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .last(last), .data(data),
        .grant(g1), .owner(o1), .net_out(n1), .net_valid(v1), .timeout_pulse(t1));
    // Plain drive, pull0 idle
    shared_net_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDLE_VAL(0), .MAX_HOLD(MH), .INVERT(0)) dut2 (
        .clk(clk), .rst(rst), .req(req), .last(last), .data(data),
        .grant(g2), .owner(o2), .net_out(n2), .net_valid(v2), .timeout_pulse(t2));

    // Reference model: who owns the net, how many beats they delivered, and
    // whether a turnaround bubble is pending.
    bit         m_active, m_bubble;
    int         m_owner, m_beats, m_last_served;
    logic [N-1:0] e_grant;
    logic [1:0] e_owner;
    logic       e_valid, e_to;
    logic [W-1:0] e_data;

    task automatic model_edge();
        bit rel;
        bit found;
        if (rst) begin
            m_active = 0; m_bubble = 0; m_owner = 0; m_beats = 0; m_last_served = N-1;
            e_grant = '0; e_owner = '0; e_valid = 0; e_to = 0; e_data = '0;
        end else begin
            e_to = 0;
            e_valid = 0;
            if (m_bubble) begin
                m_bubble = 0;
            end else if (m_active) begin
                rel = 0;
                if (!req[m_owner]) begin
                    rel = 1;
                end else begin
                    e_valid = 1;
                    e_data  = data[m_owner*W +: W];
                    m_beats++;
                    if (last[m_owner]) rel = 1;
                    else if (m_beats == MH) begin
                        rel = 1;
                        e_to = 1;
                    end
                end
                if (rel) begin
                    m_active = 0; m_bubble = 1; e_grant = '0; m_last_served = m_owner;
                end
            end else begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && req[(m_last_served + k) % N]) begin
                        found = 1;
                        m_owner = (m_last_served + k) % N;
                    end
                end
                if (found) begin
                    m_active = 1; m_beats = 0;
                    e_owner = 2'(m_owner);
                    e_grant = N'(1) << m_owner;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_net(input bit inv, input bit idle1);
        if (!e_valid) return idle1 ? {W{1'b1}} : {W{1'b0}};
        return inv ? ~e_data : e_data;
    endfunction

    task automatic compare_all();
        chk("grant0", 32'(g0), 32'(e_grant));
        chk("grant1", 32'(g1), 32'(e_grant));
        chk("grant2", 32'(g2), 32'(e_grant));
        chk("owner0", 32'(o0), 32'(e_owner));
        chk("owner1", 32'(o1), 32'(e_owner));
        chk("owner2", 32'(o2), 32'(e_owner));
        chk("net0",   32'(n0), 32'(exp_net(0, 1)));
        chk("net1",   32'(n1), 32'(exp_net(1, 1)));
        chk("net2",   32'(n2), 32'(exp_net(0, 0)));
        chk("valid0", 32'(v0), 32'(e_valid));
        chk("valid1", 32'(v1), 32'(e_valid));
        chk("valid2", 32'(v2), 32'(e_valid));
        chk("tmo0",   32'(t0), 32'(e_to));
        chk("tmo1",   32'(t1), 32'(e_to));
        chk("tmo2",   32'(t2), 32'(e_to));
        chk("onehot0", 32'($onehot0(g0)), 32'd1);
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] ls,
                        input logic [N*W-1:0] d);
        rst = r; req = rq; last = ls; data = d;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    function automatic logic [N*W-1:0] lane(input int i, input logic [W-1:0] v);
        logic [N*W-1:0] x;
        x = $urandom();
        x[i*W +: W] = v;
        return x;
    endfunction

    initial begin
        // Reset then idle
        step(1, '0, '0, '0);
        step(1, '0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            step(0, '0, '0, $urandom());
            chk("idle_ff", 32'(n0), 32'hFF);
            chk("idle_00", 32'(n2), 32'h00);
        end

        // Single burst on requester 2
        step(0, 4'b0100, 4'b0000, lane(2, 8'h00));
        chk("burst_grant", 32'(g0), 32'h4);
        step(0, 4'b0100, 4'b0000, lane(2, 8'h11));
        chk("burst_b1", 32'(n0), 32'h11);
        step(0, 4'b0100, 4'b0000, lane(2, 8'h22));
        step(0, 4'b0100, 4'b0100, lane(2, 8'h33));
        chk("burst_b3", 32'(n0), 32'h33);
        for (int i = 0; i < 3; i++) step(0, '0, '0, $urandom());

        // Round-robin, single-beat bursts
        for (int i = 0; i < 25; i++) step(0, 4'b1111, 4'b1111, $urandom());
        for (int i = 0; i < 3; i++) step(0, '0, '0, $urandom());

        // Timeout on requester 1, requester 3 joins while 1 holds
        for (int i = 0; i < 20; i++) step(0, 4'b0010, 4'b0000, $urandom());
        for (int i = 0; i < 30; i++) step(0, 4'b1010, 4'b0000, $urandom());
        for (int i = 0; i < 3; i++) step(0, '0, '0, $urandom());

        // Early drop on requester 0
        step(0, 4'b0001, 4'b0000, lane(0, 8'h0F));
        step(0, 4'b0001, 4'b0000, lane(0, 8'h0F));
        step(0, 4'b0001, 4'b0000, lane(0, 8'h0F));
        chk("inv_beat", 32'(n1), 32'hF0);
        step(0, 4'b0000, 4'b0000, lane(0, 8'h0F));
        chk("drop_idle", 32'(n1), 32'hFF);
        for (int i = 0; i < 3; i++) step(0, '0, '0, $urandom());

        // Reset during beat 3 of requester 2's burst, then 0 and 1 compete
        step(0, 4'b0100, 4'b0000, $urandom());
        step(0, 4'b0100, 4'b0000, $urandom());
        step(0, 4'b0100, 4'b0000, $urandom());
        step(1, 4'b0100, 4'b0000, $urandom());
        chk("rst_grant", 32'(g0), 32'h0);
        step(0, 4'b0011, 4'b0000, $urandom());
        chk("post_rst_grant", 32'(g0), 32'h1);
        step(0, 4'b0011, 4'b0001, $urandom());
        for (int i = 0; i < 3; i++) step(0, '0, '0, $urandom());

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0), 4'($urandom()),
                 4'($urandom() & $urandom() & $urandom()), $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
